// File: rtl/spi_master_tx.sv
// Mode-0 SPI master: a small FIFO of {last,data} words, serialized MSB first, with tx_last closing the frame.
// Defining SPI_MISO_CAPTURE_EN adds spi_miso/rx_data/rx_valid so the reply word is captured as well.
//  state | meaning
//  IDLE  | cs_n high, waiting for a queued word
//  SETUP | cs_n low, MSB on mosi, cs setup time before the first rise
//  SHIFT | sclk toggling every CLK_DIV cycles
//  STALL | mid-frame underflow; cs_n held low, sclk low
//  HOLD  | sclk low for CLK_DIV cycles before cs_n rises
//  GAP   | minimum deselect time
module spi_master_tx #(
    parameter int WORD_W     = 32,
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_cs_n,
    output logic              busy,
    output logic [15:0]       words_sent
`ifdef SPI_MISO_CAPTURE_EN
    ,
    input  logic              spi_miso,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WORD_W);
    localparam logic [CW-1:0] DIV_LOAD = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(WORD_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STALL, HOLD, GAP} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     div_cnt, div_nx;
    logic [BW-1:0]     bit_cnt, bit_nx;
    logic [WORD_W-1:0] shreg, shreg_nx;
    logic              sclk_nx, mosi_nx, cs_nx;
    logic              cur_last, last_nx;
    logic              stall_loaded, loaded_nx;
    logic              pop, load, word_done, div_tc;

    logic [WORD_W:0]   mem [FIFO_DEPTH];
    logic [AW:0]       wptr, rptr;
    logic [WORD_W:0]   head;
    logic              fifo_empty, push;

    assign fifo_empty = (wptr == rptr);
    assign tx_ready   = ((wptr - rptr) != (AW+1)'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign head       = mem[rptr[AW-1:0]];
    assign busy       = (state != IDLE);
    assign div_tc     = (div_cnt == '0);

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= {tx_last, tx_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

`ifdef SPI_MISO_CAPTURE_EN
    logic              rise;
    logic [WORD_W-1:0] rx_shreg;
`endif

    always_comb begin
        state_nx  = state;
        div_nx    = div_cnt;
        bit_nx    = bit_cnt;
        shreg_nx  = shreg;
        sclk_nx   = spi_sclk;
        mosi_nx   = spi_mosi;
        cs_nx     = spi_cs_n;
        last_nx   = cur_last;
        loaded_nx = stall_loaded;
        load      = 1'b0;
        word_done = 1'b0;
`ifdef SPI_MISO_CAPTURE_EN
        rise      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load     = 1'b1;
                    cs_nx    = 1'b0;
                    sclk_nx  = 1'b0;
                    div_nx   = DIV_LOAD;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                if (div_tc) begin
                    sclk_nx  = 1'b1;
                    div_nx   = DIV_LOAD;
                    state_nx = SHIFT;
`ifdef SPI_MISO_CAPTURE_EN
                    rise     = 1'b1;
`endif
                end else div_nx = div_cnt - CW'(1);
            end
            SHIFT: begin
                if (!div_tc) div_nx = div_cnt - CW'(1);
                else begin
                    div_nx = DIV_LOAD;
                    if (!spi_sclk) begin
                        sclk_nx = 1'b1;
`ifdef SPI_MISO_CAPTURE_EN
                        rise    = 1'b1;
`endif
                    end else begin
                        sclk_nx = 1'b0;
                        if (bit_cnt != '0) begin
                            mosi_nx  = shreg[WORD_W-1];
                            shreg_nx = {shreg[WORD_W-2:0], 1'b0};
                            bit_nx   = bit_cnt - BW'(1);
                        end else begin
                            word_done = 1'b1;
                            if (cur_last)         state_nx = HOLD;
                            else if (!fifo_empty) load     = 1'b1;
                            else begin
                                state_nx  = STALL;
                                loaded_nx = 1'b0;
                            end
                        end
                    end
                end
            end
            STALL: begin
                // First pop the next word and present its MSB, then give it a full half-period before the rise.
                if (!stall_loaded) begin
                    if (!fifo_empty) begin
                        load      = 1'b1;
                        loaded_nx = 1'b1;
                        div_nx    = DIV_LOAD;
                    end
                end else if (div_tc) begin
                    sclk_nx   = 1'b1;
                    div_nx    = DIV_LOAD;
                    loaded_nx = 1'b0;
                    state_nx  = SHIFT;
`ifdef SPI_MISO_CAPTURE_EN
                    rise      = 1'b1;
`endif
                end else div_nx = div_cnt - CW'(1);
            end
            HOLD: begin
                if (div_tc) begin
                    cs_nx    = 1'b1;
                    mosi_nx  = 1'b0;
                    div_nx   = DIV_LOAD;
                    state_nx = GAP;
                end else div_nx = div_cnt - CW'(1);
            end
            GAP: begin
                if (div_tc) state_nx = IDLE;
                else        div_nx   = div_cnt - CW'(1);
            end
            default: state_nx = IDLE;
        endcase
        if (load) begin
            mosi_nx  = head[WORD_W-1];
            shreg_nx = {head[WORD_W-2:0], 1'b0};
            last_nx  = head[WORD_W];
            bit_nx   = BIT_LOAD;
        end
        pop = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            spi_cs_n     <= 1'b1;
            cur_last     <= 1'b0;
            stall_loaded <= 1'b0;
            words_sent   <= '0;
        end else begin
            state        <= state_nx;
            div_cnt      <= div_nx;
            bit_cnt      <= bit_nx;
            shreg        <= shreg_nx;
            spi_sclk     <= sclk_nx;
            spi_mosi     <= mosi_nx;
            spi_cs_n     <= cs_nx;
            cur_last     <= last_nx;
            stall_loaded <= loaded_nx;
            if (word_done) words_sent <= words_sent + 16'd1;
        end
    end

`ifdef SPI_MISO_CAPTURE_EN
    // miso is taken at the clk edge that raises sclk, i.e. the value the slave set up on the previous fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shreg <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= word_done;
            if (rise)      rx_shreg <= {rx_shreg[WORD_W-2:0], spi_miso};
            if (word_done) rx_data  <= rx_shreg;
        end
    end
`endif
endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: a mode-0 slave model watches the SPI pins and checks words and frame timing.
module tb_spi_master_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] tx_data = '0;
    logic        tx_last = 1'b0;
    logic        spi_sclk, spi_mosi, spi_cs_n, busy;
    logic [15:0] words_sent;
`ifdef SPI_MISO_CAPTURE_EN
    logic        spi_miso = 1'b0;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [31:0] miso_pat = 32'h1234_5678;
    int          miso_idx = 31;
    int          rx_pulses = 0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    spi_master_tx #(.WORD_W(32), .CLK_DIV(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .busy(busy), .words_sent(words_sent)
`ifdef SPI_MISO_CAPTURE_EN
        , .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid)
`endif
    );

    always #5 clk = ~clk;

    // Slave model, sampled on the falling clk edge so every registered SPI output has settled.
    logic [31:0] sl_sh = '0;
    int          sl_bits = 0;
    int          rises = 0;
    int          cs_low = 0;
    int          frames = 0;
    int          viol = 0;
    logic        prev_sclk = 1'b0;
    logic        prev_cs = 1'b1;
    logic [31:0] rxq[$];

    always @(negedge clk) begin
        if (prev_cs && !spi_cs_n) begin
            sl_bits = 0;
            rises   = 0;
            cs_low  = 0;
`ifdef SPI_MISO_CAPTURE_EN
            miso_idx = 31;
            spi_miso = miso_pat[31];
`endif
        end
        if (!prev_cs && spi_cs_n) frames++;
        if (!spi_cs_n) cs_low++;
        if (spi_cs_n && spi_sclk) viol++;
        if (!spi_cs_n && !prev_sclk && spi_sclk) begin
            sl_sh = {sl_sh[30:0], spi_mosi};
            sl_bits++;
            rises++;
            if (sl_bits == 32) begin
                rxq.push_back(sl_sh);
                sl_bits = 0;
            end
        end
`ifdef SPI_MISO_CAPTURE_EN
        if (!spi_cs_n && prev_sclk && !spi_sclk && miso_idx > 0) begin
            miso_idx--;
            spi_miso = miso_pat[miso_idx];
        end
        if (rx_valid) rx_pulses++;
`endif
        prev_sclk = spi_sclk;
        prev_cs   = spi_cs_n;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling clk edge; returns on the falling edge after the word is accepted.
    task automatic push(input logic [31:0] d, input logic l);
        int n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("push_timeout", 64'd1, 64'd0);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        repeat (3) @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("idle_timeout", 64'd1, 64'd0);
        repeat (3) @(negedge clk);
    endtask

    logic [31:0] bp_words[6];
    int f0;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cs_n", 64'(spi_cs_n), 64'd1);
        check("rst_sclk", 64'(spi_sclk), 64'd0);
        check("rst_mosi", 64'(spi_mosi), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(tx_ready), 64'd1);
        check("rst_words", 64'(words_sent), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset asserted in the middle of a word
        push(32'hFFFF_FFFF, 1'b1);
        repeat (40) @(negedge clk);
        check("pre_rst_cs", 64'(spi_cs_n), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_cs_n", 64'(spi_cs_n), 64'd1);
        check("midrst_sclk", 64'(spi_sclk), 64'd0);
        check("midrst_mosi", 64'(spi_mosi), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_ready", 64'(tx_ready), 64'd1);
        check("midrst_words", 64'(words_sent), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        rxq.delete();

        // Single word frame
        f0 = frames;
        push(32'hA5A5_0F0F, 1'b1);
        wait_idle();
        check("single_nwords", 64'(rxq.size()), 64'd1);
        if (rxq.size() == 1) check("single_data", 64'(rxq[0]), 64'hA5A5_0F0F);
        check("single_cs_low", 64'(cs_low), 64'd130);
        check("single_rises", 64'(rises), 64'd32);
        check("single_frames", 64'(frames - f0), 64'd1);
        check("single_words_sent", 64'(words_sent), 64'd1);
        rxq.delete();

        // Three-word burst in one frame
        f0 = frames;
        push(32'hDEAD_BEEF, 1'b0);
        push(32'h0123_4567, 1'b0);
        push(32'h8000_0001, 1'b1);
        wait_idle();
        check("burst_nwords", 64'(rxq.size()), 64'd3);
        if (rxq.size() == 3) begin
            check("burst_w0", 64'(rxq[0]), 64'hDEAD_BEEF);
            check("burst_w1", 64'(rxq[1]), 64'h0123_4567);
            check("burst_w2", 64'(rxq[2]), 64'h8000_0001);
        end
        check("burst_rises", 64'(rises), 64'd96);
        check("burst_cs_low", 64'(cs_low), 64'd386);
        check("burst_frames", 64'(frames - f0), 64'd1);
        check("burst_words_sent", 64'(words_sent), 64'd4);
        rxq.delete();

        // Underflow: second word arrives long after the first finished
        f0 = frames;
        push(32'hCAFE_F00D, 1'b0);
        repeat (200) @(negedge clk);
        check("stall_cs_n", 64'(spi_cs_n), 64'd0);
        check("stall_sclk", 64'(spi_sclk), 64'd0);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_words_sent", 64'(words_sent), 64'd5);
        check("stall_no_frame_end", 64'(frames - f0), 64'd0);
        push(32'h5A5A_5A5A, 1'b1);
        wait_idle();
        check("stall_nwords", 64'(rxq.size()), 64'd2);
        if (rxq.size() == 2) begin
            check("stall_w0", 64'(rxq[0]), 64'hCAFE_F00D);
            check("stall_w1", 64'(rxq[1]), 64'h5A5A_5A5A);
        end
        check("stall_rises", 64'(rises), 64'd64);
        check("stall_frames", 64'(frames - f0), 64'd1);
        check("stall_words_sent2", 64'(words_sent), 64'd6);
        rxq.delete();

        // Backpressure: six words into a four-deep FIFO
        f0 = frames;
        for (int i = 0; i < 6; i++) bp_words[i] = 32'h0102_0304 + 32'h1111_1111 * i;
        for (int i = 0; i < 5; i++) push(bp_words[i], 1'b0);
        check("bp_ready_full", 64'(tx_ready), 64'd0);
        push(bp_words[5], 1'b1);
        wait_idle();
        check("bp_nwords", 64'(rxq.size()), 64'd6);
        if (rxq.size() == 6)
            for (int i = 0; i < 6; i++) check($sformatf("bp_w%0d", i), 64'(rxq[i]), 64'(bp_words[i]));
        check("bp_frames", 64'(frames - f0), 64'd1);
        check("bp_words_sent", 64'(words_sent), 64'd12);
        check("bp_ready_after", 64'(tx_ready), 64'd1);
        rxq.delete();

`ifdef SPI_MISO_CAPTURE_EN
        // Reply capture on miso
        rx_pulses = 0;
        push(32'h0000_0000, 1'b1);
        wait_idle();
        check("miso_pulses", 64'(rx_pulses), 64'd1);
        check("miso_rx_data", 64'(rx_data), 64'h1234_5678);
        check("miso_rx_valid_low", 64'(rx_valid), 64'd0);
`endif

        check("sclk_while_deselected", 64'(viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
